// File: rtl/pwm_seq_controller.sv
// Chase-pattern sequencer and host write arbiter driving the PWM driver's pset/addr/level port.
// Optional build macro PWM_SEQ_HOST_LOCK_EN: host-written channels are locked out of auto frames.
module pwm_seq_controller #(
  parameter int NUM_CH  = 7,
  parameter int LEVEL_W = 3,
  parameter int DIV_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [DIV_W-1:0]   div,
  input  logic               host_req,
  input  logic [2:0]         host_addr,
  input  logic [LEVEL_W-1:0] host_level,
  output logic               host_ack,
  output logic               pset,
  output logic [2:0]         addr,
  output logic [LEVEL_W-1:0] level,
  output logic               busy,
  output logic               frame_done
);

  localparam int CH_W = $clog2(NUM_CH + 1);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t               state, state_d;
  logic [CH_W-1:0]      ch, ch_d;
  logic                 frame_active, frame_active_d;
  logic                 cur_host, cur_host_d;
  logic [LEVEL_W-1:0]   phase, phase_d;
  logic [DIV_W-1:0]     count;
  logic                 tick_pending;
  logic                 start_frame;
  logic                 host_ok;
  logic [2:0]           addr_d;
  logic [LEVEL_W-1:0]   level_d;
  logic                 pset_d, host_ack_d, frame_done_d;
  logic [NUM_CH-1:0]    lock_eff;
  logic [CH_W:0]        first_ch, next_ch;

  // Lowest unlocked channel at or above start; MSB flags that one exists.
  function automatic logic [CH_W:0] find_next(input int start, input logic [NUM_CH-1:0] lk);
    logic [CH_W:0] r;
    r = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (i >= start && !lk[i]) r = {1'b1, CH_W'(i)};
    end
    return r;
  endfunction

`ifdef PWM_SEQ_HOST_LOCK_EN
  logic [NUM_CH-1:0] lock;
  logic              host_lock_hit;

  assign host_lock_hit = (state == HOLD) && cur_host && (int'(addr) < NUM_CH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             lock <= '0;
    else if (!enable)       lock <= '0;
    else if (host_lock_hit) lock[addr] <= 1'b1;
  end

  // The host write finishing this cycle already counts, so the frame skips it.
  always_comb begin
    lock_eff = lock;
    if (host_lock_hit) lock_eff[addr] = 1'b1;
  end
`else
  assign lock_eff = '0;
`endif

  assign first_ch = find_next(0, lock_eff);
  assign next_ch  = find_next(int'(ch) + 1, lock_eff);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count        <= '0;
      tick_pending <= 1'b0;
    end else if (!enable) begin
      count        <= '0;
      tick_pending <= 1'b0;
    end else if (count >= div) begin
      count        <= '0;
      tick_pending <= 1'b1;
    end else begin
      count <= count + DIV_W'(1);
      if (start_frame) tick_pending <= 1'b0;
    end
  end

  // Handshake: host_req is held with stable host_addr/host_level until host_ack
  // pulses (cycle after the host HOLD); the request is ignored in that HOLD and in
  // the ack cycle so one request yields exactly one write.
  assign host_ok = host_req && !host_ack && !((state == HOLD) && cur_host);

  always_comb begin
    state_d        = state;
    ch_d           = ch;
    frame_active_d = frame_active;
    cur_host_d     = cur_host;
    phase_d        = phase;
    addr_d         = addr;
    level_d        = level;
    pset_d         = 1'b0;
    host_ack_d     = 1'b0;
    frame_done_d   = 1'b0;
    start_frame    = 1'b0;
    case (state)
      IDLE: begin
        if (host_ok) begin
          state_d    = SETUP;
          cur_host_d = 1'b1;
          addr_d     = host_addr;
          level_d    = host_level;
        end else if (tick_pending && enable) begin
          start_frame = 1'b1;
          if (first_ch[CH_W]) begin
            frame_active_d = 1'b1;
            state_d        = SETUP;
            cur_host_d     = 1'b0;
            ch_d           = first_ch[CH_W-1:0];
            addr_d         = 3'(first_ch[CH_W-1:0]);
            level_d        = phase + LEVEL_W'(first_ch[CH_W-1:0]);
          end else begin
            frame_done_d = 1'b1;
            phase_d      = phase + LEVEL_W'(1);
          end
        end
      end
      SETUP: begin
        state_d = STROBE;
        pset_d  = 1'b1;
      end
      STROBE: state_d = HOLD;
      HOLD: begin
        state_d = IDLE;
        if (cur_host) host_ack_d = 1'b1;
        if (frame_active && !next_ch[CH_W]) begin
          frame_done_d   = 1'b1;
          phase_d        = phase + LEVEL_W'(1);
          frame_active_d = 1'b0;
        end else if (!enable) begin
          frame_active_d = 1'b0;
        end
        // Frames launch only from IDLE, so back-to-back frames keep one decision cycle.
        if (host_ok) begin
          state_d    = SETUP;
          cur_host_d = 1'b1;
          addr_d     = host_addr;
          level_d    = host_level;
        end else if (frame_active_d) begin
          state_d    = SETUP;
          cur_host_d = 1'b0;
          ch_d       = next_ch[CH_W-1:0];
          addr_d     = 3'(next_ch[CH_W-1:0]);
          level_d    = phase + LEVEL_W'(next_ch[CH_W-1:0]);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      ch           <= '0;
      frame_active <= 1'b0;
      cur_host     <= 1'b0;
      phase        <= '0;
      addr         <= '0;
      level        <= '0;
      pset         <= 1'b0;
      host_ack     <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      state        <= state_d;
      ch           <= ch_d;
      frame_active <= frame_active_d;
      cur_host     <= cur_host_d;
      phase        <= phase_d;
      addr         <= addr_d;
      level        <= level_d;
      pset         <= pset_d;
      host_ack     <= host_ack_d;
      frame_done   <= frame_done_d;
    end
  end

  assign busy = (state != IDLE);

endmodule
